// File: rtl/otter_md_pkg.sv
// Shared types and constants for the OTTER RV32M multiply/divide unit.
//   md_op_t    : FUNCT3 encodings of the eight RV32M operations
//   md_state_t : control states of the iterative unit
//   abs_sign() : magnitude of an operand, optionally treated as signed
package otter_md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } md_state_t;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Two's-complement magnitude when the operand is signed and negative.
    function automatic logic [31:0] abs_sign(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
// restoring shift-subtract divide) sharing one 64-bit shift register.
// Ports:
//   CLK, RST_N      : clock, asynchronous active-low reset
//   START           : request, accepted only in IDLE
//   FUNCT3          : RV32M operation select
//   SRC_A, SRC_B    : rs1 / rs2 operands, latched on the accepting edge
//   RESULT          : result, held until the next accepted START
//   BUSY            : high in CALC and FIN
//   DONE            : one-cycle pulse in FIN, RESULT valid that cycle
module mul_div_unit
    import otter_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE
);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    md_op_t             r_op;
    logic               r_sign;
    logic [31:0]        r_opnd;     // multiplicand or divisor magnitude
    logic [63:0]        r_acc;      // {product hi / remainder, multiplier / dividend->quotient}
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_result;

    md_op_t             w_op_in;
    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic               w_sign_in;
    logic               w_div0;
    logic               w_ovf;
    logic               w_fast;
    logic [31:0]        w_fast_res;
    logic               w_last;
    logic [32:0]        w_mul_sum;
    logic [32:0]        w_div_shift;
    logic [31:0]        w_div_diff;
    logic               w_div_ge;
    logic [63:0]        w_acc_nxt;
    logic [63:0]        w_prod_fix;
    logic [31:0]        w_q_fix;
    logic [31:0]        w_r_fix;
    logic [31:0]        w_final;

    assign w_op_in    = md_op_t'(FUNCT3);
    assign w_is_div   = FUNCT3[2];
    assign w_a_signed = (w_op_in == OP_MULH) || (w_op_in == OP_MULHSU) ||
                        (w_op_in == OP_DIV)  || (w_op_in == OP_REM);
    assign w_b_signed = (w_op_in == OP_MULH) || (w_op_in == OP_DIV) || (w_op_in == OP_REM);
    assign w_a_mag    = abs_sign(SRC_A, w_a_signed);
    assign w_b_mag    = abs_sign(SRC_B, w_b_signed);
    assign w_div0     = w_is_div && (SRC_B == 32'd0);
    assign w_ovf      = ((w_op_in == OP_DIV) || (w_op_in == OP_REM)) &&
                        (SRC_A == INT_MIN) && (SRC_B == DIV0_Q);
    assign w_fast     = w_div0 || w_ovf;
    assign w_last     = (r_cnt == CNT_W'(MD_ITER - 1));

    // Result sign: quotient/product sign is the XOR of signed operand signs,
    // remainder sign follows the dividend.
    always_comb begin
        w_sign_in = 1'b0;
        case (w_op_in)
            OP_MULH, OP_DIV: w_sign_in = SRC_A[31] ^ SRC_B[31];
            OP_MULHSU:       w_sign_in = SRC_A[31];
            OP_REM:          w_sign_in = SRC_A[31];
            default:         w_sign_in = 1'b0;
        endcase
    end

    // Fast-path results; bit 1 of FUNCT3 separates REM* from DIV*.
    always_comb begin
        w_fast_res = 32'd0;
        if (w_div0) begin
            w_fast_res = FUNCT3[1] ? SRC_A : DIV0_Q;
        end else begin
            w_fast_res = FUNCT3[1] ? 32'd0 : INT_MIN;
        end
    end

    assign w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // When the trial succeeds the new remainder is below the divisor, so 32 bits suffice.
    assign w_div_diff  = w_div_shift[31:0] - r_opnd;

    // One iteration of the shared shift datapath.
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_op[2]) begin
            if (w_div_ge) begin
                w_acc_nxt = {w_div_diff, r_acc[30:0], 1'b1};
            end else begin
                w_acc_nxt = {w_div_shift[31:0], r_acc[30:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_nxt = {w_mul_sum, r_acc[31:1]};
            end else begin
                w_acc_nxt = {1'b0, r_acc[63:1]};
            end
        end
    end

    assign w_prod_fix = r_sign ? (64'd0 - w_acc_nxt) : w_acc_nxt;
    assign w_q_fix    = r_sign ? (32'd0 - w_acc_nxt[31:0]) : w_acc_nxt[31:0];
    assign w_r_fix    = r_sign ? (32'd0 - w_acc_nxt[63:32]) : w_acc_nxt[63:32];

    // Final result selection on the last iteration.
    always_comb begin
        w_final = 32'd0;
        case (r_op)
            OP_MUL:                      w_final = w_prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[63:32];
            OP_DIV, OP_DIVU:             w_final = w_q_fix;
            OP_REM, OP_REMU:             w_final = w_r_fix;
            default:                     w_final = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; FIN always returns to IDLE so START there is never accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = w_fast ? FIN : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op     <= OP_MUL;
            r_sign   <= 1'b0;
            r_opnd   <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= '0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_op   <= w_op_in;
                        r_sign <= w_sign_in;
                        r_cnt  <= '0;
                        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc  <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
                        if (w_fast) begin
                            r_result <= w_fast_res;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_final;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign RESULT = r_result;
    assign BUSY   = (r_state != IDLE);
    assign DONE   = (r_state == FIN);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized
// operations against an arithmetic reference model, busy/restart and
// mid-operation reset sequences.
module tb_mul_div_unit;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] SRC_A;
    logic [31:0] SRC_B;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .FUNCT3 (FUNCT3),
        .SRC_A  (SRC_A),
        .SRC_B  (SRC_B),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / integer arithmetic following the RV32M rules.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one operation; scramble the inputs after the accepting edge.
    // lat counts clock edges from the START edge (inclusive) to the DONE cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge CLK);
        START  = 1'b1;
        FUNCT3 = f;
        SRC_A  = a;
        SRC_B  = b;
        lat    = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            START  = 1'b0;
            FUNCT3 = 3'($urandom_range(0, 7));
            SRC_A  = $urandom;
            SRC_B  = $urandom;
        end while (!DONE && lat < 100);
        res = RESULT;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        int          lat;
        logic        busy_ok;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[2]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[5]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[7]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33};
        vecs[8]  = '{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 33};
        vecs[9]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[10] = '{3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[13] = '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};

        RST_N  = 1'b0;
        START  = 1'b0;
        FUNCT3 = 3'b000;
        SRC_A  = 32'd0;
        SRC_B  = 32'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset RESULT", RESULT, 32'd0);
        chk("reset BUSY", {31'd0, BUSY}, 32'd0);
        chk("reset DONE", {31'd0, DONE}, 32'd0);
        RST_N = 1'b1;

        // Directed vectors, including the one-cycle DONE pulse and result hold.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            @(negedge CLK);
            chk($sformatf("vec%0d done pulse", i), {30'd0, BUSY, DONE}, 32'd0);
            chk($sformatf("vec%0d held", i), RESULT, vecs[i].exp);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_val();
            rb = pick_val();
            run_op(rf, ra, rb, res, lat);
            chk($sformatf("rand%0d f=%0d a=%h b=%h result", i, rf, ra, rb), res, ref_md(rf, ra, rb));
            chk($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(rf, ra, rb)));
        end

        // START while busy is ignored; START in FIN is not accepted.
        @(negedge CLK);
        START  = 1'b1;
        FUNCT3 = 3'b100;
        SRC_A  = 32'd100;
        SRC_B  = 32'd7;
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (lat == 9) begin
                START  = 1'b1;
                FUNCT3 = 3'b000;
                SRC_A  = 32'd3;
                SRC_B  = 32'd5;
            end else begin
                START = 1'b0;
            end
            if (!BUSY) busy_ok = 1'b0;
        end while (!DONE && lat < 100);
        chk("busy restart result", RESULT, 32'd14);
        chk("busy restart latency", 32'(lat), 32'd33);
        chk("busy held high", {31'd0, busy_ok}, 32'd1);
        START  = 1'b1;
        FUNCT3 = 3'b000;
        SRC_A  = 32'd9;
        SRC_B  = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        chk("start in FIN rejected", {30'd0, BUSY, DONE}, 32'd0);
        chk("start in FIN result held", RESULT, 32'd14);

        // Asynchronous reset in the middle of a multiply.
        @(negedge CLK);
        START  = 1'b1;
        FUNCT3 = 3'b000;
        SRC_A  = 32'd1234;
        SRC_B  = 32'd5678;
        repeat (15) begin
            @(posedge CLK);
            #1 START = 1'b0;
        end
        #2 RST_N = 1'b0;
        #1;
        chk("abort BUSY", {31'd0, BUSY}, 32'd0);
        chk("abort DONE", {31'd0, DONE}, 32'd0);
        chk("abort RESULT", RESULT, 32'd0);
        @(negedge CLK);
        chk("abort held", {30'd0, BUSY, DONE}, 32'd0);
        RST_N = 1'b1;
        run_op(3'b000, 32'd1234, 32'd5678, res, lat);
        chk("after reset result", res, 32'd7006652);
        chk("after reset latency", 32'(lat), 32'd33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the OTTER execute stage.
- Sits beside the ALU and consumes the same operand-mux outputs (SRC_A, SRC_B).
- Produces a 32-bit RESULT for the writeback mux.
- Uses a START/BUSY/DONE handshake so the control FSM can stall fetch until DONE.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported for RV32M.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request; sampled only in IDLE
- FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SRC_A  input  32  rs1 operand (multiplicand / dividend)
- SRC_B  input  32  rs2 operand (multiplier / divisor)
- RESULT  output  32  registered result; held until the next accepted START
- BUSY  output  1  high in CALC and FIN
- DONE  output  1  one-cycle pulse in FIN; RESULT is valid that cycle

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, RESULT=0, BUSY=0, DONE=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIN.
- IDLE + START=1 at an edge: latch FUNCT3 and operands.
  - Record the result sign.
  - Convert operands to magnitudes:
    - MULH: both operands signed.
    - MULHSU: A signed, B unsigned.
    - DIV/REM: both signed.
    - MUL/MULHU/DIVU/REMU: unsigned magnitudes.
  - Next state is CALC, counter=0.
- Fast paths, evaluated in IDLE on START; these go straight to FIN, so DONE arrives 1 cycle after the START edge:
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result SRC_A.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- CALC: one iteration per edge for exactly 32 edges.
  - Multiply: radix-2 shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract; 32-bit remainder with a 33-bit compare; quotient shifted in LSB-first.
  - On the edge where counter==31: apply sign fix-up (two's-complement negate when the sign flag is set), load RESULT, go to FIN.
- Result selection:
  - MUL: low product word.
  - MULH/MULHSU/MULHU: high word of the signed-corrected 64-bit product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Remainder sign follows the dividend; quotient sign is the XOR of the operand signs (signed ops only).
- Normal latency: START edge to the DONE cycle is 33 clocks.
- FIN: DONE=1, BUSY=1 for one cycle, then IDLE unconditionally.
- START while BUSY is ignored, and START in FIN is not accepted. The earliest next accept is the first IDLE cycle.
- Operands/FUNCT3 may change after the START edge without effect, because they are latched.
- RESULT is stable from FIN until the next accepted START; it is not cleared by returning to IDLE.
- RST_N low mid-operation: immediate abort to the reset values, with no DONE pulse.
- Arithmetic wraps modulo 2^32; no exceptions are raised, per the RISC-V spec.

Decomposition:
- Package otter_md_pkg holds:
  - typedef enum md_op_t for the 8 FUNCT3 encodings.
  - typedef enum md_state_t {IDLE, CALC, FIN}.
  - Constants MD_ITER=32, DIV0_Q=32'hFFFF_FFFF, INT_MIN=32'h8000_0000.
- A single module is natural; the shared shift datapath does not justify a sub-module.
- An optional helper function abs_sign() also belongs in the package.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD (−3) -> DONE after 33 cycles, RESULT 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> RESULT 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIVU 5/0 -> DONE 1 cycle after START, RESULT 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle; REM same operands -> 0.
- START re-asserted with new operands at cycle 10 of a DIV -> ignored; original result delivered at cycle 33; BUSY stays high throughout.
- RST_N pulled low at cycle 15 of a MUL -> BUSY/DONE/RESULT go to 0 asynchronously; a following START completes normally with the correct result.
